// File: rtl/slot_bank_writer_12.sv
`default_nettype none
// ============================================================================
// Module      : slot_bank_writer_12
// Description : Demultiplexes handshaked records into 12 held slot registers,
//               with addressed or auto-fill writes and a sequenced clear.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_bank_writer_12 #(
    parameter int W       = 63,
    parameter int N_SLOTS = 12
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] In,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic [3:0]   Sel,
    input  logic         Auto,
    input  logic         Clear,
    output logic [W-1:0] Out1,
    output logic [W-1:0] Out2,
    output logic [W-1:0] Out3,
    output logic [W-1:0] Out4,
    output logic [W-1:0] Out5,
    output logic [W-1:0] Out6,
    output logic [W-1:0] Out7,
    output logic [W-1:0] Out8,
    output logic [W-1:0] Out9,
    output logic [W-1:0] Out10,
    output logic [W-1:0] Out11,
    output logic [W-1:0] Out12,
    output logic [11:0]  Slot_Valid,
    output logic [3:0]   Count,
    output logic         Full,
    output logic         Busy,
    output logic         Err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [3:0] c_NSLOTS = 4'(N_SLOTS);
    localparam logic [3:0] c_LAST   = 4'(N_SLOTS - 1);

    logic [0:0]   r_state;
    logic [W-1:0] r_slot [12];
    logic [11:0]  r_valid;
    logic [3:0]   r_ptr;
    logic [3:0]   r_idx;
    logic [3:0]   r_count;
    logic         r_err;

    logic [3:0]   w_tgt;
    logic         w_tgt_ok;
    logic         w_fire;

    assign Full     = (r_count == c_NSLOTS);
    assign Busy     = (r_state == S_CLEAR);
    assign In_Ready = (r_state == S_IDLE) & ~Clear & ~(Auto & Full);
    assign w_fire   = In_Valid & In_Ready;
    assign w_tgt    = Auto ? r_ptr : Sel;
    assign w_tgt_ok = (w_tgt < c_NSLOTS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Clear) begin
                        r_state <= S_CLEAR;
                        r_idx   <= '0;
                    end else if (w_fire) begin
                        if (w_tgt_ok) begin
                            r_slot[w_tgt]  <= In;
                            r_valid[w_tgt] <= 1'b1;
                            if (!r_valid[w_tgt]) begin
                                r_count <= r_count + 4'd1;
                            end
                        end else begin
                            // Out-of-range address: record is consumed and dropped
                            r_err <= ~Auto;
                        end
                        if (Auto && (r_ptr < c_NSLOTS)) begin
                            r_ptr <= r_ptr + 4'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_slot[r_idx]  <= '0;
                    r_valid[r_idx] <= 1'b0;
                    if (r_idx == c_LAST) begin
                        r_state <= S_IDLE;
                        r_ptr   <= '0;
                        r_count <= '0;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Out1       = r_slot[0];
    assign Out2       = r_slot[1];
    assign Out3       = r_slot[2];
    assign Out4       = r_slot[3];
    assign Out5       = r_slot[4];
    assign Out6       = r_slot[5];
    assign Out7       = r_slot[6];
    assign Out8       = r_slot[7];
    assign Out9       = r_slot[8];
    assign Out10      = r_slot[9];
    assign Out11      = r_slot[10];
    assign Out12      = r_slot[11];
    assign Slot_Valid = r_valid;
    assign Count      = r_count;
    assign Err        = r_err;

endmodule
`default_nettype wire
